// File: rtl/cpu_pkg.sv
// Shared CPU constants: mux select encodings and the default register-address width.
package cpu_pkg;

  localparam logic MUX_SEL_A = 1'b0;
  localparam logic MUX_SEL_B = 1'b1;

  localparam int unsigned REG_ADDR_W = 5;

endpackage : cpu_pkg

// File: rtl/mux_5_sel_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule : sat_counter

// File: rtl/mux_5_sel.sv
// 2:1 operand selector with a zero-latency output, a registered copy with a valid flag,
// and per-input saturating usage counters.
module mux_5_sel
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = REG_ADDR_W,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             control,
  input  logic [WIDTH-1:0] in_data_a,
  input  logic [WIDTH-1:0] in_data_b,
  input  logic             en,
  input  logic             clr_cnt,
  output logic [WIDTH-1:0] out_data,
  output logic [WIDTH-1:0] out_data_q,
  output logic             out_valid,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  logic inc_a;
  logic inc_b;

  // Plain conditional so an unknown select propagates instead of defaulting to A.
  assign out_data = control ? in_data_b : in_data_a;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q <= '0;
      out_valid  <= 1'b0;
    end else if (en) begin
      out_data_q <= out_data;
      out_valid  <= 1'b1;
    end
  end

  assign inc_a = en && (control == MUX_SEL_A);
  assign inc_b = en && (control == MUX_SEL_B);

  sat_counter #(.CNT_W(CNT_W)) u_cnt_a (
    .clk (clk),
    .rst (rst),
    .inc (inc_a),
    .clr (clr_cnt),
    .cnt (cnt_a)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt_b (
    .clk (clk),
    .rst (rst),
    .inc (inc_b),
    .clr (clr_cnt),
    .cnt (cnt_b)
  );

endmodule : mux_5_sel

// File: tb/tb_mux_5_sel.sv
// Directed self-checking bench for mux_5_sel.
`timescale 1ns/1ps
module tb_mux_5_sel;

  logic       clk = 1'b0;
  logic       rst;
  logic       control;
  logic [4:0] in_data_a;
  logic [4:0] in_data_b;
  logic       en;
  logic       clr_cnt;
  logic [4:0] out_data;
  logic [4:0] out_data_q;
  logic       out_valid;
  logic [7:0] cnt_a;
  logic [7:0] cnt_b;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [4:0] exp_q;
  logic       exp_v;
  logic [7:0] exp_ca;
  logic [7:0] exp_cb;
  logic [4:0] exp_sel;

  mux_5_sel #(.WIDTH(5), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .control    (control),
    .in_data_a  (in_data_a),
    .in_data_b  (in_data_b),
    .en         (en),
    .clr_cnt    (clr_cnt),
    .out_data   (out_data),
    .out_data_q (out_data_q),
    .out_valid  (out_valid),
    .cnt_a      (cnt_a),
    .cnt_b      (cnt_b)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance the reference state across one rising edge, then sample 1 ns later.
  task automatic clk_edge();
    if (en) begin
      exp_q = (control == 1'b0) ? in_data_a : in_data_b;
      exp_v = 1'b1;
    end
    if (clr_cnt) begin
      exp_ca = '0;
      exp_cb = '0;
    end else if (en) begin
      if (control == 1'b0 && exp_ca != 8'hFF) exp_ca = exp_ca + 8'd1;
      if (control == 1'b1 && exp_cb != 8'hFF) exp_cb = exp_cb + 8'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".q"},     32'(out_data_q), 32'(exp_q));
    check({tag, ".valid"}, 32'(out_valid),  32'(exp_v));
    check({tag, ".cnt_a"}, 32'(cnt_a),      32'(exp_ca));
    check({tag, ".cnt_b"}, 32'(cnt_b),      32'(exp_cb));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr_cnt = 1'b0; control = 1'b0;
    in_data_a = 5'h03; in_data_b = 5'h09;
    exp_q = '0; exp_v = 1'b0; exp_ca = '0; exp_cb = '0;

    // Reset held for two cycles; combinational path live throughout.
    @(posedge clk); #1;
    check("rst.out_data", 32'(out_data), 32'h03);
    @(posedge clk); #1;
    check_regs("rst");
    rst = 1'b0;
    clk_edge();
    check_regs("post_rst_en0");
    check("post_rst.out_data", 32'(out_data), 32'h03);

    // Zero-latency select, no clock involved.
    in_data_a = 5'h1F; in_data_b = 5'h00; control = 1'b0;
    #1 check("comb.sel_a", 32'(out_data), 32'h1F);
    control = 1'b1;
    #1 check("comb.sel_b", 32'(out_data), 32'h00);
    check("comb.q_held", 32'(out_data_q), 32'h00);

    // Walk: a decrements, b increments, control toggles every two cycles.
    en = 1'b1;
    in_data_a = 5'd7; in_data_b = 5'd0; control = 1'b0;
    for (int step = 0; step < 10; step++) begin
      exp_sel = control ? in_data_b : in_data_a;
      #1 check($sformatf("walk%0d.out_data", step), 32'(out_data), 32'(exp_sel));
      for (int k = 0; k < 2; k++) begin
        clk_edge();
        check_regs($sformatf("walk%0d_%0d", step, k));
        check($sformatf("walk%0d_%0d.q_is_sel", step, k), 32'(out_data_q), 32'(exp_sel));
      end
      in_data_a = in_data_a - 5'd1;
      in_data_b = in_data_b + 5'd1;
      control   = ~control;
    end

    // Wrap stimulus: values pass through bit-exact.
    in_data_a = 5'd0; control = 1'b0;
    in_data_a = in_data_a - 5'd1;
    #1 check("wrap.a_1F", 32'(out_data), 32'h1F);
    clk_edge();
    check("wrap.q_1F", 32'(out_data_q), 32'h1F);
    in_data_b = 5'h1F; control = 1'b1;
    in_data_b = in_data_b + 5'd1;
    #1 check("wrap.b_00", 32'(out_data), 32'h00);
    clk_edge();
    check("wrap.q_00", 32'(out_data_q), 32'h00);
    check_regs("wrap");

    // en=0 holds everything.
    en = 1'b0; in_data_a = 5'h0C; control = 1'b0;
    clk_edge();
    check_regs("hold");
    check("hold.q_00", 32'(out_data_q), 32'h00);

    // Saturation of cnt_a.
    en = 1'b1; clr_cnt = 1'b1;
    clk_edge();
    check_regs("clr0");
    clr_cnt = 1'b0;
    for (int i = 0; i < 255; i++) clk_edge();
    check("sat.cnt_a_255", 32'(cnt_a), 32'd255);
    for (int i = 0; i < 45; i++) clk_edge();
    check_regs("sat300");
    check("sat.cnt_b_0", 32'(cnt_b), 32'd0);

    // Clear wins over simultaneous increment; registered path unaffected.
    clr_cnt = 1'b1;
    clk_edge();
    check_regs("clr_win");
    check("clr_win.cnt_a_0", 32'(cnt_a), 32'd0);
    clr_cnt = 1'b0;
    clk_edge();
    check("clr_after.cnt_a_1", 32'(cnt_a), 32'd1);

    // Asynchronous reset mid-cycle.
    in_data_a = 5'h15; control = 1'b0;
    clk_edge();
    check("arst.pre_q", 32'(out_data_q), 32'h15);
    #4 rst = 1'b1;
    #1;
    check("arst.q", 32'(out_data_q), 32'h00);
    check("arst.valid", 32'(out_valid), 32'h0);
    check("arst.cnt_a", 32'(cnt_a), 32'h0);
    check("arst.out_data", 32'(out_data), 32'h15);
    exp_q = '0; exp_v = 1'b0; exp_ca = '0; exp_cb = '0;
    #2 rst = 1'b0;
    in_data_a = 5'h0A;
    clk_edge();
    check_regs("arst_release");
    check("arst_release.q_0A", 32'(out_data_q), 32'h0A);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule : tb_mux_5_sel

// File: doc/mux_5_sel.md
Name: mux_5_sel

Overview:
- 5-bit (parameterisable) 2:1 selector for datapath operand muxing in the MIPS CPU.
- Provides two outputs:
  - out_data: combinational, zero-latency selected value.
  - out_data_q: registered copy with a valid flag.
- Also keeps saturating usage counters for each input, so the select path can be observed in simulation and debug.

Parameters:
- WIDTH, 5, data width of both inputs and the outputs.
- CNT_W, 8, width of each per-input selection counter.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- control  input  1  select: 0 picks in_data_a, 1 picks in_data_b.
- in_data_a  input  WIDTH  operand A.
- in_data_b  input  WIDTH  operand B.
- en  input  1  capture enable for the registered path and counters.
- clr_cnt  input  1  synchronous clear of both counters.
- out_data  output  WIDTH  combinational selected value.
- out_data_q  output  WIDTH  registered selected value.
- out_valid  output  1  out_data_q holds a value captured since reset.
- cnt_a  output  CNT_W  number of enabled cycles that selected A (saturating).
- cnt_b  output  CNT_W  number of enabled cycles that selected B (saturating).

Behaviour:
- Combinational path:
  - out_data = control ? in_data_b : in_data_a, with zero latency.
  - Unaffected by clk, rst and en; valid even while rst is asserted.
  - An X or Z on control must not be masked. Behavioural models use a plain conditional; no default-to-A.
- Reset: while rst=1, asynchronously force out_data_q=0, out_valid=0, cnt_a=0, cnt_b=0.
- Registered path, on each rising clk edge with rst=0 and en=1:
  - out_data_q <= the combinational select value.
  - out_valid <= 1.
- en=0: out_data_q, out_valid and both counters hold.
- Latency: out_data_q follows the inputs by exactly 1 cycle when en=1.
- Counters, on an enabled edge:
  - control=0 increments cnt_a; control=1 increments cnt_b.
  - Each counter saturates at 2^CNT_W-1 (255 by default) and never wraps.
- clr_cnt=1 on an edge zeroes both counters. It wins over a simultaneous increment and does not affect out_data_q or out_valid.
- Reset mid-operation: asynchronous clear takes effect immediately, mid-cycle. The first enabled edge after rst deasserts captures normally.
- Data width rule:
  - No arithmetic on data; values pass through bit-exact.
  - Stimulus wider than WIDTH is truncated to its low WIDTH bits at the port.

Decomposition:
- Shared package (cpu_pkg) holds:
  - MUX_SEL_A = 1'b0 and MUX_SEL_B = 1'b1.
  - The default data width constant (5) for register-address-width selects.
- One natural sub-module: sat_counter (CNT_W-bit, inc/clr/saturate), instantiated twice.
- The mux itself stays inline.

Test Plan:
- rst=1 for 2 cycles, then released with en=0 -> out_data_q=0, out_valid=0, cnt_a=cnt_b=0. out_data still tracks the inputs combinationally.
- a=5'h1F, b=5'h00, control=0 -> out_data=5'h1F immediately. Toggle control=1 -> out_data=5'h00 in the same time step, with no clock needed.
- en=1, then every 40 ns (2 clk periods): a decrements, b increments and control toggles, starting a=5'd7, b=0, control=0. Check:
  - out_data equals a when control=0 and b when control=1.
  - out_data_q equals the previous cycle's out_data.
  - out_valid=1 after the first edge.
- Wrap stimulus: a=5'd0 then a-1 -> a=5'h1F, selected unchanged (no sign or width extension). b=5'h1F then +1 -> b=5'h00.
- Hold en=1, control=0 for 300 cycles -> cnt_a saturates at 255 and stays. cnt_b=0. Assert clr_cnt with control=0 on one edge -> cnt_a=0 on that edge, no increment.
- Assert rst asynchronously between edges while out_data_q=5'h15 -> out_data_q=0 and out_valid=0 before the next edge. The first enabled edge after release captures the current select value.
